// File: rtl/xalu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// E stage drives the request; the unit returns busy and the HI/LO pair.
interface xalu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/xalu.sv
// Multi-cycle mult/div unit with HI/LO: result lands N cycles after start (busy high N cycles),
// mthi/mtlo write in one edge; starts while busy are dropped, no backpressure beyond busy.
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset_n,
    xalu_if.slave   xif
);
    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] hi, hi_n, lo, lo_n;
    logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sb_safe, q_s, r_s;
    logic        [31:0] ub_safe, q_u, r_u;
    logic               b_zero, div_ovf;
    logic        [63:0] result;

    // Divisors are forced to 1 in the special cases so the datapath never
    // evaluates x/0 or INT_MIN/-1; the real results are substituted below.
    always_comb begin
        b_zero  = (xif.b == 32'h0);
        div_ovf = (xif.a == 32'h8000_0000) && (xif.b == 32'hFFFF_FFFF);
        prod_s  = $signed({{32{xif.a[31]}}, xif.a}) * $signed({{32{xif.b[31]}}, xif.b});
        prod_u  = {32'h0, xif.a} * {32'h0, xif.b};
        sb_safe = (b_zero || div_ovf) ? 32'sd1 : $signed(xif.b);
        ub_safe = b_zero ? 32'd1 : xif.b;
        q_s     = $signed(xif.a) / sb_safe;
        r_s     = $signed(xif.a) % sb_safe;
        q_u     = xif.a / ub_safe;
        r_u     = xif.a % ub_safe;
    end

    always_comb begin
        result = 64'h0;
        case (xif.op)
            3'd0: result = prod_s;
            3'd1: result = prod_u;
            3'd2: begin
                if (b_zero)       result = {xif.a, 32'hFFFF_FFFF};
                else if (div_ovf) result = {32'h0, 32'h8000_0000};
                else              result = {r_s, q_s};
            end
            3'd3: result = b_zero ? {xif.a, 32'hFFFF_FFFF} : {r_u, q_u};
            default: result = 64'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'h0;
            lo      <= 32'h0;
            pend_hi <= 32'h0;
            pend_lo <= 32'h0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        case (state)
            IDLE: begin
                if (xif.start) begin
                    case (xif.op)
                        3'd0, 3'd1: begin
                            {pend_hi_n, pend_lo_n} = result;
                            cnt_n   = MULT_N;
                            state_n = RUN;
                        end
                        3'd2, 3'd3: begin
                            {pend_hi_n, pend_lo_n} = result;
                            cnt_n   = DIV_N;
                            state_n = RUN;
                        end
                        3'd4:    hi_n = xif.a;
                        3'd5:    lo_n = xif.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any start seen here is dropped; only the countdown advances.
                if (cnt == 4'd1) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign xif.busy = (state == RUN);
    assign xif.hi   = hi;
    assign xif.lo   = lo;
endmodule

// File: tb/tb_xalu.sv
// Directed scoreboard bench for xalu: stimulus queues expectations, a monitor checks them.
module tb_xalu;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    xalu_if xif ();

    xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .xif     (xif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
    } res_t;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
    } snap_t;

    res_t  res_q[$];
    snap_t snap_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    bit    abort_pending = 1'b0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    int busy_cnt = 0;
    bit held_ok  = 1'b1;
    bit prev_busy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            chk("snap_hi", s.id, xif.hi, s.hi);
            chk("snap_lo", s.id, xif.lo, s.lo);
            chk("snap_busy", s.id, {31'h0, xif.busy}, 32'h0);
        end
        if (xif.busy) begin
            busy_cnt++;
            if (res_q.size() > 0 && (xif.hi !== res_q[0].pre_hi || xif.lo !== res_q[0].pre_lo))
                held_ok = 1'b0;
        end else if (prev_busy) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
            end else if (res_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: busy fell with nothing expected, hi=%h lo=%h", xif.hi, xif.lo);
            end else begin
                res_t r;
                r = res_q.pop_front();
                chk("res_hi", r.id, xif.hi, r.hi);
                chk("res_lo", r.id, xif.lo, r.lo);
                chk("busy_len", r.id, busy_cnt, r.len);
                chk("hold_prev", r.id, {31'h0, held_ok}, 32'h1);
            end
            busy_cnt = 0;
            held_ok  = 1'b1;
        end
        prev_busy = xif.busy;
    end

    task automatic expect_res(input int id, input logic [31:0] hi, input logic [31:0] lo, input int len);
        res_t r;
        r.id = id; r.hi = hi; r.lo = lo; r.len = len; r.pre_hi = m_hi; r.pre_lo = m_lo;
        res_q.push_back(r);
        m_hi = hi;
        m_lo = lo;
    endtask

    task automatic expect_snap(input int id);
        snap_t s;
        s.id = id; s.hi = m_hi; s.lo = m_lo;
        snap_q.push_back(s);
    endtask

    // One-cycle start pulse; operands are scrambled afterwards.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        xif.start = 1'b1; xif.op = op; xif.a = a; xif.b = b;
        @(negedge clk);
        xif.start = 1'b0; xif.a = 32'h5A5A_A5A5; xif.b = 32'h0000_0013;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (res_q.size() > 0 || snap_q.size() > 0); i++) @(negedge clk);
        if (res_q.size() > 0 || snap_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: %0d results and %0d snapshots still pending", res_q.size(), snap_q.size());
            res_q.delete();
            snap_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        xif.start = 1'b0; xif.op = 3'd0; xif.a = 32'h0; xif.b = 32'h0;
        @(negedge clk);
        expect_snap(0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_drain();

        expect_res(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);  issue(3'd0, 32'hFFFF_FFFF, 32'h2); wait_drain();
        expect_res(2, 32'h0000_0001, 32'hFFFF_FFFE, 5);  issue(3'd1, 32'hFFFF_FFFF, 32'h2); wait_drain();
        expect_res(3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10); issue(3'd2, 32'hFFFF_FFF9, 32'h2); wait_drain();
        expect_res(4, 32'h0000_0001, 32'h7FFF_FFFC, 10); issue(3'd3, 32'hFFFF_FFF9, 32'h2); wait_drain();
        expect_res(5, 32'h0000_0001, 32'hFFFF_FFFD, 10); issue(3'd2, 32'h0000_0007, 32'hFFFF_FFFE); wait_drain();

        // mthi then mtlo back to back, then a reserved op.
        @(negedge clk);
        xif.start = 1'b1; xif.op = 3'd4; xif.a = 32'h1234_5678;
        m_hi = 32'h1234_5678; expect_snap(6);
        @(negedge clk);
        xif.op = 3'd5; xif.a = 32'h9ABC_DEF0;
        m_lo = 32'h9ABC_DEF0; expect_snap(7);
        @(negedge clk);
        xif.op = 3'd6; xif.a = 32'h1111_1111;
        expect_snap(8);
        @(negedge clk);
        xif.start = 1'b0;
        wait_drain();

        // A div issued on busy cycle 2 of a multu must be ignored.
        expect_res(9, 32'h0, 32'h0000_000C, 5);
        issue(3'd1, 32'h3, 32'h4);
        @(negedge clk);
        xif.start = 1'b1; xif.op = 3'd2; xif.a = 32'h8; xif.b = 32'h2;
        @(negedge clk);
        xif.start = 1'b0;
        wait_drain();

        expect_res(10, 32'h0000_0055, 32'hFFFF_FFFF, 10); issue(3'd2, 32'h0000_0055, 32'h0); wait_drain();
        expect_res(11, 32'h0000_0077, 32'hFFFF_FFFF, 10); issue(3'd3, 32'h0000_0077, 32'h0); wait_drain();
        expect_res(12, 32'h0, 32'h8000_0000, 10);         issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain();

        // Reset mid-clock on busy cycle 4 of a div.
        abort_pending = 1'b1;
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 13, {31'h0, xif.busy}, 32'h0);
        chk("rst_hi", 13, xif.hi, 32'h0);
        chk("rst_lo", 13, xif.lo, 32'h0);
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            expect_snap(14 + i);
            @(negedge clk);
        end
        wait_drain();
        chk("abort_seen", 34, {31'h0, abort_pending}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
